// File: rtl/mux4_scan_sequencer_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer: FSM state encodings,
// channel index constants and the enabled-channel search helper.
package mux4_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StHold   = 2'd3
  } state_e;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  // Returns {found, index} of the lowest enabled channel at or above 'from'.
  function automatic logic [2:0] next_enabled(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k] && (3'(k) >= from)) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4_scan_sequencer_settle_counter.sv
// Settle-time counter: counts while enabled, done when the settle window has elapsed.
module scan_settle_counter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SETTLE_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [SETTLE_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + SETTLE_W'(1);
    end
  end

  assign done = (count_q == SETTLE_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/mux4_scan_sequencer.sv
// Scans mux channels A..D, samples f after a settle time, and offers the 4-bit
// snapshot on valid/ready. Optional channel masking: define SCAN_MASK_EN.
module mux4_scan_sequencer
  import mux4_scan_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SETTLE_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_f,
`ifdef SCAN_MASK_EN
  input  logic [3:0] scan_mask,
`endif
  output logic       sel_s0,
  output logic       sel_s1,
  output logic       busy,
  output logic       snap_valid,
  input  logic       snap_ready,
  output logic [3:0] snap_data,
  output logic       overrun
);

  state_e     state_q, state_d;
  logic [1:0] channel_q, channel_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] snap_data_q, snap_data_d;
  logic       snap_valid_q, snap_valid_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;
  logic       cnt_clear, cnt_en, cnt_done;
`ifdef SCAN_MASK_EN
  logic [3:0] mask_q, mask_d;
  logic [2:0] nxt;
`endif

  scan_settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .SETTLE_W     (SETTLE_W)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .enable(cnt_en),
    .done  (cnt_done)
  );

  always_comb begin
    state_d      = state_q;
    channel_d    = channel_q;
    sel_d        = sel_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
`ifdef SCAN_MASK_EN
    mask_d       = mask_q;
    nxt          = 3'b000;
`endif

    if (start && (state_q != StIdle)) overrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          overrun_d = 1'b0;
          busy_d    = 1'b1;
          cnt_clear = 1'b1;
`ifdef SCAN_MASK_EN
          mask_d      = scan_mask;
          snap_data_d = 4'b0000;
          nxt         = next_enabled(scan_mask, 3'd0);
          if (nxt[2]) begin
            channel_d = nxt[1:0];
            sel_d     = nxt[1:0];
            state_d   = StSettle;
          end else begin
            state_d = StHold;
          end
`else
          channel_d = CH_A;
          sel_d     = CH_A;
          state_d   = StSettle;
`endif
        end
      end
      StSettle: begin
        cnt_en = 1'b1;
        if (cnt_done) state_d = StSample;
      end
      StSample: begin
        snap_data_d[channel_q] = mux_f;
`ifdef SCAN_MASK_EN
        nxt = next_enabled(mask_q, {1'b0, channel_q} + 3'd1);
        if (nxt[2]) begin
          channel_d = nxt[1:0];
          sel_d     = nxt[1:0];
          cnt_clear = 1'b1;
          state_d   = StSettle;
        end else begin
          state_d = StHold;
        end
`else
        if (channel_q != CH_D) begin
          channel_d = channel_q + 2'd1;
          sel_d     = channel_q + 2'd1;
          cnt_clear = 1'b1;
          state_d   = StSettle;
        end else begin
          state_d = StHold;
        end
`endif
      end
      StHold: begin
        // First HOLD cycle raises valid; later cycles wait for the handshake.
        if (!snap_valid_q) begin
          snap_valid_d = 1'b1;
        end else if (snap_ready) begin
          snap_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      channel_q    <= CH_A;
      sel_q        <= 2'b00;
      snap_data_q  <= 4'b0000;
      snap_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SCAN_MASK_EN
      mask_q       <= 4'b0000;
`endif
    end else begin
      state_q      <= state_d;
      channel_q    <= channel_d;
      sel_q        <= sel_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
`ifdef SCAN_MASK_EN
      mask_q       <= mask_d;
`endif
    end
  end

  assign sel_s0     = sel_q[1];
  assign sel_s1     = sel_q[0];
  assign busy       = busy_q;
  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Bench for mux4_scan_sequencer with a behavioural 4:1 mux on its selects.
module tb_mux4_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       snap_ready = 1'b0;
  logic [3:0] chan_in = 4'b0000;
  logic       mux_f;
  logic       sel_s0, sel_s1, busy, snap_valid, overrun;
  logic [3:0] snap_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Channel k = {S0,S1} drives f from input k.
  assign mux_f = chan_in[{sel_s0, sel_s1}];

  mux4_scan_sequencer #(
    .SETTLE_CYCLES(2),
    .SETTLE_W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mux_f     (mux_f),
    .sel_s0    (sel_s0),
    .sel_s1    (sel_s1),
    .busy      (busy),
    .snap_valid(snap_valid),
    .snap_ready(snap_ready),
    .snap_data (snap_data),
    .overrun   (overrun)
  );

  typedef struct {
    logic [3:0] in_vec;
    logic [3:0] exp_data;
    int         ready_wait;
    bit         poke;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic scan_check(input vec_t v);
    logic [3:0] in_now;
    int exp_ch;
    in_now     = v.in_vec;
    chan_in    = in_now;
    snap_ready = (v.ready_wait == 0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_at_start", busy, 1);
    chk("overrun_cleared", overrun, 0);
    chk("sel_at_start", {sel_s0, sel_s1}, 0);
    for (int n = 1; n <= 12; n++) begin
      if (v.poke && n == 1) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      exp_ch = (n / 3 > 3) ? 3 : n / 3;
      chk("sel_sequence", {sel_s0, sel_s1}, exp_ch);
      chk("valid_early", snap_valid, 0);
      chk("busy_scan", busy, 1);
      if (v.poke && n == 2) chk("overrun_settle", overrun, 1);
    end
    @(posedge clk);
    #1;
    chk("valid_cycle13", snap_valid, 1);
    chk("data_cycle13", snap_data, v.exp_data);
    chk("busy_cycle13", busy, 1);
    for (int i = 0; i < v.ready_wait; i++) begin
      in_now  = ~in_now;
      chan_in = in_now;
      if (v.poke && i == 0) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("valid_held", snap_valid, 1);
      chk("data_held", snap_data, v.exp_data);
    end
    snap_ready = 1'b1;
    @(posedge clk);
    #1 snap_ready = 1'b0;
    chk("valid_after_hs", snap_valid, 0);
    chk("busy_after_hs", busy, 0);
    chk("data_after_hs", snap_data, v.exp_data);
    chk("overrun_after_hs", overrun, {31'b0, v.poke});
  endtask

  vec_t vecs[5];
  bit   saw_valid;

  initial begin
    vecs[0] = '{in_vec: 4'b0101, exp_data: 4'b0101, ready_wait: 0, poke: 1'b0};
    vecs[1] = '{in_vec: 4'b1010, exp_data: 4'b1010, ready_wait: 5, poke: 1'b0};
    vecs[2] = '{in_vec: 4'b0011, exp_data: 4'b0011, ready_wait: 3, poke: 1'b1};
    vecs[3] = '{in_vec: 4'b0000, exp_data: 4'b0000, ready_wait: 0, poke: 1'b1};
    vecs[4] = '{in_vec: 4'b1101, exp_data: 4'b1101, ready_wait: 2, poke: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", snap_valid, 0);
    chk("reset_data", snap_data, 0);
    chk("reset_sel", {sel_s0, sel_s1}, 0);
    chk("reset_overrun", overrun, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) scan_check(vecs[i]);

    // Reset in the middle of SETTLE after a non-zero snapshot.
    chan_in = 4'b1111;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy_before_rst", busy, 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", snap_valid, 0);
    chk("rst_data", snap_data, 0);
    chk("rst_sel", {sel_s0, sel_s1}, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk) rst_n = 1'b1;
    snap_ready = 1'b1;
    saw_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1 if (snap_valid) saw_valid = 1'b1;
    end
    snap_ready = 1'b0;
    chk("no_valid_after_rst", saw_valid, 0);
    chk("idle_after_rst", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
